// File: rtl/rsa_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_decoder
//  Purpose  : RSA decryption engine for the 8-bit RSA link. Recovers the
//             plaintext as cipher_data^D mod N using right-to-left
//             square-and-multiply. Each multiply and each modular reduction
//             takes one registered step.
//  Ports    : clk              - system clock, rising edge
//             reset            - synchronous, active-high, overrides all inputs
//             cipher_data      - 16-bit ciphertext, sampled on the accept edge
//             input_data_ready - start request, honoured only in IDLE
//             busy             - high while a decode is in flight
//             done             - result valid (level), held until next accept
//             range_error      - cipher_data >= N at accept, valid with done
//             output_data      - recovered plaintext (result[7:0])
//  Config   : RSA_DEC_CONST_TIME_EN - when defined, the multiply/reduce of the
//             accumulator runs for every exponent bit. Latency is then fixed
//             at 4*EXP_W. Results are identical in both builds.
//  Revision : 1.0 - initial release
// ============================================================================
module rsa_decoder #(
  parameter int unsigned N     = 3233,  // modulus, < 2^16
  parameter int unsigned D     = 2753,  // private exponent, fits in EXP_W bits
  parameter int unsigned EXP_W = 12     // exponent bits processed, LSB first
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cipher_data,
  input  logic        input_data_ready,
  output logic        busy,
  output logic        done,
  output logic        range_error,
  output logic [7:0]  output_data
);

  localparam int unsigned       CNT_W  = $clog2(EXP_W) + 1;
  localparam logic [15:0]       N16    = N[15:0];
  localparam logic [31:0]       N32    = {16'd0, N16};
  localparam logic [EXP_W-1:0]  D_BITS = D[EXP_W-1:0];
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(EXP_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL_R = 3'd1,
    ST_MOD_R = 3'd2,
    ST_MUL_B = 3'd3,
    ST_MOD_B = 3'd4
  } state_e;

  state_e             state_q;
  logic [15:0]        result_q;
  logic [15:0]        base_q;
  logic [31:0]        prod_q;
  logic [EXP_W-1:0]   exp_q;
  logic [CNT_W-1:0]   cnt_q;

  // Datapath next values shared by the FSM states
  logic [15:0]        mul_a_d;
  logic [31:0]        prod_d;
  logic [15:0]        mod_d;
  logic [EXP_W-1:0]   exp_d;
  logic               last_bit_d;
  logic               range_bad_d;

  // The multiplier's left operand is the accumulator in MUL_R and the base
  // in MUL_B; the right operand is always the base.
  assign mul_a_d     = (state_q == ST_MUL_R) ? result_q : base_q;
  assign prod_d      = 32'(mul_a_d) * 32'(base_q);
  // prod_q % N is always < N < 2^16, so the truncation loses nothing.
  assign mod_d       = 16'(prod_q % N32);
  assign exp_d       = exp_q >> 1;
  assign last_bit_d  = (cnt_q == CNT_ONE);
  assign range_bad_d = (cipher_data >= N16);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      base_q      <= '0;
      prod_q      <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      range_error <= 1'b0;
      output_data <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (input_data_ready) begin
            if (range_bad_d) begin
              // Rejected in a single cycle; no computation is started.
              done        <= 1'b1;
              range_error <= 1'b1;
              output_data <= '0;
            end else begin
              result_q    <= 16'd1;
              base_q      <= cipher_data;
              exp_q       <= D_BITS;
              cnt_q       <= CNT_INIT;
              busy        <= 1'b1;
              done        <= 1'b0;
              range_error <= 1'b0;
`ifdef RSA_DEC_CONST_TIME_EN
              state_q     <= ST_MUL_R;
`else
              state_q     <= D_BITS[0] ? ST_MUL_R : ST_MUL_B;
`endif
            end
          end
        end

        ST_MUL_R: begin
          prod_q  <= prod_d;
          state_q <= ST_MOD_R;
        end

        ST_MOD_R: begin
          // In the variable-time build this state is only reached when the
          // bit is set, so the guard matters only for constant-time mode.
          if (exp_q[0]) begin
            result_q <= mod_d;
          end
          state_q <= ST_MUL_B;
        end

        ST_MUL_B: begin
          prod_q  <= prod_d;
          state_q <= ST_MOD_B;
        end

        ST_MOD_B: begin
          // The square on the final bit is computed and discarded so that
          // every bit follows the same control path.
          base_q <= mod_d;
          exp_q  <= exp_d;
          cnt_q  <= cnt_q - CNT_ONE;
          if (last_bit_d) begin
            output_data <= result_q[7:0];
            done        <= 1'b1;
            busy        <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
`ifdef RSA_DEC_CONST_TIME_EN
            state_q <= ST_MUL_R;
`else
            state_q <= exp_d[0] ? ST_MUL_R : ST_MUL_B;
`endif
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rsa_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rsa_decoder
//  Purpose  : Directed self-checking bench for rsa_decoder (N=3233, D=2753).
//             Expected plaintexts are hand-computed: 2790->65, 0->0, 1->1,
//             524 (=66^17 mod 3233)->66, 3232 (=-1 mod N, D odd)->160.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_decoder;

`ifdef RSA_DEC_CONST_TIME_EN
  localparam int LAT = 48;
`else
  localparam int LAT = 34;   // 2*12 + 2*popcount(2753)=2*5
`endif

  logic        clk;
  logic        reset;
  logic [15:0] cipher_data;
  logic        input_data_ready;
  logic        busy;
  logic        done;
  logic        range_error;
  logic [7:0]  output_data;

  int tests;
  int failed;

  rsa_decoder dut (
    .clk              (clk),
    .reset            (reset),
    .cipher_data      (cipher_data),
    .input_data_ready (input_data_ready),
    .busy             (busy),
    .done             (done),
    .range_error      (range_error),
    .output_data      (output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for done. Reports latency (edges after the
  // accept edge), whether busy behaved, and whether done dropped on accept.
  // repulse_at > 0 re-raises input_data_ready with cipher_data=1 at that cycle.
  task automatic decode(input logic [15:0] c, input int repulse_at,
                        output int lat, output logic busy_ok, output logic done_clr);
    int cyc;
    @(negedge clk);
    cipher_data      = c;
    input_data_ready = 1'b1;
    @(posedge clk);
    #1;
    input_data_ready = 1'b0;
    busy_ok  = busy;
    done_clr = ~done;
    lat      = -1;
    cyc      = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      input_data_ready = 1'b0;
      if (done) begin
        lat = cyc;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (cyc == repulse_at) begin
        cipher_data      = 16'd1;
        input_data_ready = 1'b1;
      end
    end
  endtask

  initial begin
    int       lat;
    logic     bok;
    logic     dclr;
    logic     busy_seen;
    tests = 0;
    failed = 0;
    reset = 1'b1;
    cipher_data = '0;
    input_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rerr", range_error, 0);
    check("rst_out", output_data, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic decode
    decode(16'd2790, 0, lat, bok, dclr);
    check("d2790_out", output_data, 65);
    check("d2790_rerr", range_error, 0);
    check("d2790_lat", lat, LAT);
    check("d2790_busy", bok, 1);
    repeat (3) @(posedge clk);
    #1;
    check("d2790_hold_done", done, 1);
    check("d2790_hold_out", output_data, 65);

    // Edge plaintext values, issued back to back while done is held
    decode(16'd0, 0, lat, bok, dclr);
    check("d0_done_clr", dclr, 1);
    check("d0_out", output_data, 0);
    check("d0_lat", lat, LAT);
    decode(16'd1, 0, lat, bok, dclr);
    check("d1_out", output_data, 1);
    check("d1_lat", lat, LAT);

    // Loopback: 66^17 mod 3233 = 524
    decode(16'd524, 0, lat, bok, dclr);
    check("loop_out", output_data, 66);
    check("loop_busy", bok, 1);

    // Largest in-range ciphertext: (N-1)^odd = N-1 = 3232, low byte 160
    decode(16'd3232, 0, lat, bok, dclr);
    check("d3232_out", output_data, 160);
    check("d3232_rerr", range_error, 0);

    // Range error at exactly N
    @(negedge clk);
    cipher_data = 16'd3233;
    input_data_ready = 1'b1;
    @(posedge clk);
    #1;
    input_data_ready = 1'b0;
    check("rerr_done", done, 1);
    check("rerr_flag", range_error, 1);
    check("rerr_out", output_data, 0);
    busy_seen = busy;
    repeat (4) begin
      @(posedge clk);
      #1;
      busy_seen = busy_seen | busy;
    end
    check("rerr_busy", busy_seen, 0);
    check("rerr_hold", range_error, 1);

    // Range error at the top of the input range
    decode(16'd2790, 0, lat, bok, dclr);
    @(negedge clk);
    cipher_data = 16'hFFFF;
    input_data_ready = 1'b1;
    @(posedge clk);
    #1;
    input_data_ready = 1'b0;
    check("rffff_flag", range_error, 1);
    check("rffff_out", output_data, 0);

    // Reset mid-decode, with a simultaneous request that must be dropped
    @(negedge clk);
    cipher_data = 16'd2790;
    input_data_ready = 1'b1;
    @(posedge clk);
    #1;
    input_data_ready = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    input_data_ready = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_out", output_data, 0);
    @(negedge clk);
    reset = 1'b0;
    input_data_ready = 1'b0;
    busy_seen = 1'b0;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      busy_seen = busy_seen | busy | done;
    end
    check("mrst_quiet", busy_seen, 0);
    decode(16'd2790, 0, lat, bok, dclr);
    check("post_rst_out", output_data, 65);
    check("post_rst_lat", lat, LAT);

    // Request during decode is ignored
    decode(16'd2790, 5, lat, bok, dclr);
    check("repulse_out", output_data, 65);
    check("repulse_lat", lat, LAT);
    repeat (3) @(posedge clk);
    #1;
    check("repulse_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rsa_decoder.md
# rsa_decoder

RSA decryption engine, receive side of the 8-bit RSA link: accepts a 16-bit ciphertext produced by the existing encoder path (controller + datapath, m^e mod n) and recovers the 8-bit plaintext as c^d mod n. It uses iterative right-to-left square-and-multiply with a registered multiply step and a registered modulo step. It is a single FSM plus datapath and is paired with the encoder in loopback benches.

## Interface
- N, 3233: modulus (61*53); must be < 2^16.
- D, 2753: private exponent; must fit in EXP_W bits.
- EXP_W, 12: exponent bit count processed, MSB to LSB order irrelevant (LSB first).
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; overrides every other input.
- cipher_data  input  16  ciphertext; sampled only on the accept edge.
- input_data_ready  input  1  start request; honoured only in IDLE.
- busy  output  1  high from the cycle after accept until done rises.
- done  output  1  result valid; level, held until next accept or reset.
- range_error  output  1  cipher_data >= N on accept; valid while done=1.
- output_data  output  8  plaintext = result[7:0]; held while done=1.

## Operation
- Registers: result[15:0], base[15:0], prod[31:0], exp[EXP_W-1:0], cnt (log2(EXP_W)+1 bits).
- States: IDLE, MUL_R, MOD_R, MUL_B, MOD_B.
- IDLE: on input_data_ready=1:
  - If cipher_data >= N: stay in IDLE; set done=1, range_error=1, output_data=0.
  - Else: load result=1, base=cipher_data, exp=D, cnt=EXP_W; clear done and range_error; go to MUL_R if exp[0]=1, else to MUL_B.
- MUL_R: prod = result*base (16x16 -> 32, full width, no truncation). Next state MOD_R.
- MOD_R: result = prod % N. Next state MUL_B.
- MUL_B: prod = base*base. Next state MOD_B.
- MOD_B: base = prod % N; exp = exp >> 1; cnt = cnt-1.
  - If cnt was 1: output_data = result[7:0], done=1, go to IDLE.
  - Else: go to MUL_R if the new exp[0]=1, else to MUL_B.
- The final square is computed and discarded; this is accepted for uniform control.
- input_data_ready while not in IDLE is ignored; cipher_data is not re-sampled.
- Reset: state=IDLE; busy=0, done=0, range_error=0, output_data=0; internal registers cleared. Reset mid-operation aborts the computation with no done pulse.
- Simultaneous reset and input_data_ready: reset wins; the request is dropped.

## Timing
- Accept edge = edge 0 (IDLE with input_data_ready=1).
- busy rises after edge 0 and falls at the edge where done rises.
- Latency, valid ciphertext: done=1 after edge 2*EXP_W + 2*popcount(D), or 4*EXP_W when RSA_DEC_CONST_TIME_EN is defined.
  - Defaults: 34 cycles (popcount(2753)=5).
  - Defaults with RSA_DEC_CONST_TIME_EN: 48 cycles.
- Latency, range error: done=1 after edge 0, i.e. 1 cycle; busy stays 0.
- A back-to-back request is accepted on the same edge where done would hold; done then drops on that accept edge.
- output_data and range_error are stable for as long as done=1.

## Configuration
- RSA_DEC_CONST_TIME_EN defined: MUL_R/MOD_R execute for every exponent bit. MOD_R writes result only when the current exp[0]=1 and leaves it unchanged otherwise. Latency is fixed at 4*EXP_W, independent of D.
- RSA_DEC_CONST_TIME_EN undefined: MUL_R/MOD_R are skipped for zero bits. Latency is data-dependent as specified in Timing.
- Results are identical in both builds.

## Test plan
- cipher_data=2790, 1-cycle input_data_ready pulse -> output_data=65, range_error=0, done after 34 cycles (48 with RSA_DEC_CONST_TIME_EN); busy high throughout.
- cipher_data=0, then cipher_data=1 -> output_data=0, then output_data=1; each done at the same latency as above.
- cipher_data=3233 -> done=1 and range_error=1 one cycle after accept; output_data=0; busy never high.
- Loopback: encoder with data=66 produces ciphertext C; decoder given C -> output_data=66.
- Reset asserted 10 cycles into decode of 2790 -> next cycle busy=0, done=0, output_data=0. A new request for 2790 then completes normally with output_data=65.
- input_data_ready re-pulsed with cipher_data=1 mid-decode of 2790 -> request ignored; result is 65 at the original latency.
